sensor_pkt_spi_master: RTL and testbench
========================================

# sensor_pkt_spi_master

SPI Mode 0 master that reads 16-byte sensor packets from the FPGA-side sensor SPI slave. It waits for the slave's `done`, clocks out 128 bits, and checks the 0xAA header. It then unpacks quaternion and gyro words and acknowledges with a `load` pulse. It sits in the on-FPGA loopback/self-test path, taking the place of the MCU, so that the sensor link can be exercised and checked without external hardware.

## Interface
- CLK_DIV, 4: `clk` cycles per `sck` half-period; legal 2..255.
- LOAD_CYCLES, 8: `clk` cycles `load` is held high during acknowledge; legal 1..255. Must exceed the slave's synchronizer depth plus one.
- ACK_TIMEOUT, 1024: `clk` cycles allowed for `done` to fall after `load`; legal 1..65535.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  allow new transfers; sampled only in IDLE.
- sck  out  1  SPI clock; idles low.
- sdo  out  1  MOSI; constant 0.
- sdi  in  1  MISO from slave.
- done  in  1  slave data-ready (asynchronous; 2-flop synchronized internally).
- load  out  1  acknowledge to slave.
- busy  out  1  high whenever FSM ≠ IDLE.
- quat_w, quat_x, quat_y, quat_z  out  16 each, signed  last accepted quaternion.
- gyro_x, gyro_y, gyro_z  out  16 each, signed  last accepted gyro.
- quat_valid, gyro_valid  out  1 each  flag bits 0/1 of last accepted packet.
- pkt_valid  out  1  one-cycle pulse when the data outputs update.
- hdr_err  out  1  one-cycle pulse on header mismatch.
- ack_err  out  1  one-cycle pulse on acknowledge timeout.

## Operation
- Packet is MSB-first: byte0 header 0xAA; bytes 1–8 hold w,x,y,z (MSB,LSB each); bytes 9–14 hold gyro x,y,z (MSB,LSB); byte15 holds flags {6'b0, gyro_valid, quat_valid}.
- IDLE: `sck`=0, `load`=0. When `en` && `done_s` (synchronized), go to SHIFT.
- SHIFT: 128 bit periods.
  - Each period is `sck` low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - `sdi` is shifted into a 128-bit register on the last `clk` cycle of each high phase, before the falling edge.
  - A 7-bit bit counter is used; after the bit-127 high phase, `sck` returns low and the FSM goes to CHECK.
- CHECK (1 cycle):
  - Header == 0xAA: update all data/flag outputs and pulse `pkt_valid`.
  - Otherwise: pulse `hdr_err` and hold the outputs.
  - Go to ACK in either case.
- ACK: `load`=1 for LOAD_CYCLES cycles, then `load`=0 and go to WAIT_CLR.
- WAIT_CLR: when `done_s`=0, go to IDLE. After ACK_TIMEOUT cycles with `done_s` still 1, pulse `ack_err` and go to IDLE.
- Boundaries:
  - `en` dropping mid-transfer does not abort; the transfer, CHECK and ACK complete.
  - `done` falling during SHIFT is ignored; all 128 bits are still clocked.
  - Reset mid-operation: `sck`, `load` and `busy` drop on the reset assertion edge, and partial shift data is discarded.
  - Sign is taken as-is from the MSB byte; no extension or saturation.

## Timing
- Reset values: `sck`=0, `sdo`=0, `load`=0, `busy`=0, all data outputs 0, all flags and pulses 0.
- `done` to first `sck` rise = 2 (sync) + 1 (IDLE decision) + CLK_DIV cycles.
- SHIFT duration = 256·CLK_DIV cycles.
- `pkt_valid`/`hdr_err` fire 1 cycle after the final falling `sck`.
- `load` rises the cycle after CHECK and stays high for exactly LOAD_CYCLES cycles.
- Minimum IDLE-to-IDLE time = 3 + 256·CLK_DIV + 1 + LOAD_CYCLES + (clear latency) cycles.
- All outputs are registered.

## Configuration
- PKT_HDR_CHECK_EN defined: behaviour as above; a mismatch produces `hdr_err` and no output update.
- Not defined: the header is not compared, and every packet updates the outputs and pulses `pkt_valid`. `hdr_err` is tied 0.

## Test plan
- Slave model holds quat {0x4000,0xFFFF,0x0001,0x8000}, gyro {0x0123,0xFEDC,0x7FFF}, flags 0x03; assert `done` -> one `pkt_valid`; `quat_w`=0x4000, `quat_z`=-32768, `gyro_y`=0xFEDC, both valids 1; `load` high exactly 8 cycles.
- Slave sends header 0x55 (macro defined) -> `hdr_err` pulse, outputs keep previous values, `load` still pulses. With the macro undefined -> `pkt_valid` instead.
- CLK_DIV=2 -> exactly 128 `sck` rising edges; each high and low phase is 2 cycles; `sck` low in IDLE.
- Slave holds `done` high after `load` -> `ack_err` at ACK_TIMEOUT, then IDLE. A new transfer starts only if `en` is set and `done` is still high.
- `rst_n` pulsed low at bit 60 -> `sck`/`load`/`busy` immediately 0, outputs 0. The next `done` gives a clean full packet.
- `en`=0 with `done` high -> no `sck` activity. `en` deasserted at bit 10 -> the transfer completes with `pkt_valid`.

Source files
------------

// File: rtl/sensor_pkt_spi_master.sv
`default_nettype none
// ============================================================================
// sensor_pkt_spi_master : SPI mode-0 master that reads 16-byte sensor packets
// and acknowledges with load. Optional macro: PKT_HDR_CHECK_EN. Revision 1.0
// ============================================================================
module sensor_pkt_spi_master #(
  parameter int CLK_DIV     = 4,
  parameter int LOAD_CYCLES = 8,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               sck,
  output logic               sdo,
  input  logic               sdi,
  input  logic               done,
  output logic               load,
  output logic               busy,
  output logic signed [15:0] quat_w,
  output logic signed [15:0] quat_x,
  output logic signed [15:0] quat_y,
  output logic signed [15:0] quat_z,
  output logic signed [15:0] gyro_x,
  output logic signed [15:0] gyro_y,
  output logic signed [15:0] gyro_z,
  output logic               quat_valid,
  output logic               gyro_valid,
  output logic               pkt_valid,
  output logic               hdr_err,
  output logic               ack_err
);

  // Without the header check the header byte simply falls off the top.
`ifdef PKT_HDR_CHECK_EN
  localparam int SR_W = 128;
`else
  localparam int SR_W = 120;
`endif
  localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [15:0] LOAD_LAST = 16'(LOAD_CYCLES - 1);
  localparam logic [15:0] ACK_LAST  = 16'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, ACK, WAIT_CLR} state_t;

  state_t          state, state_nx;
  logic            done_meta, done_s;
  logic [7:0]      div_cnt, div_cnt_nx;
  logic [6:0]      bit_cnt, bit_cnt_nx;
  logic [15:0]     cnt, cnt_nx;
  logic [SR_W-1:0] sr, sr_nx;
  logic            sck_nx, load_nx, accept;
  logic            pkt_valid_nx, hdr_err_nx, ack_err_nx;

  assign sdo = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_meta <= 1'b0;
      done_s    <= 1'b0;
    end else begin
      done_meta <= done;
      done_s    <= done_meta;
    end
  end

  always_comb begin
`ifdef PKT_HDR_CHECK_EN
    accept = (sr[127:120] == 8'hAA);
`else
    accept = 1'b1;
`endif
  end

  always_comb begin
    state_nx     = state;
    div_cnt_nx   = div_cnt;
    bit_cnt_nx   = bit_cnt;
    cnt_nx       = cnt;
    sr_nx        = sr;
    sck_nx       = sck;
    load_nx      = load;
    pkt_valid_nx = 1'b0;
    hdr_err_nx   = 1'b0;
    ack_err_nx   = 1'b0;
    case (state)
      IDLE: begin
        sck_nx  = 1'b0;
        load_nx = 1'b0;
        if (en && done_s) begin
          state_nx   = SHIFT;
          div_cnt_nx = 8'd0;
          bit_cnt_nx = 7'd0;
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nx = 8'd0;
          sck_nx     = ~sck;
          // End of a high phase: capture before sck falls.
          if (sck) begin
            sr_nx      = {sr[SR_W-2:0], sdi};
            bit_cnt_nx = bit_cnt + 7'd1;
            if (bit_cnt == 7'd127) state_nx = CHECK;
          end
        end else begin
          div_cnt_nx = div_cnt + 8'd1;
        end
      end
      CHECK: begin
        pkt_valid_nx = accept;
        hdr_err_nx   = ~accept;
        load_nx      = 1'b1;
        cnt_nx       = 16'd0;
        state_nx     = ACK;
      end
      ACK: begin
        if (cnt == LOAD_LAST) begin
          load_nx  = 1'b0;
          cnt_nx   = 16'd0;
          state_nx = WAIT_CLR;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      WAIT_CLR: begin
        if (!done_s) begin
          state_nx = IDLE;
        end else if (cnt == ACK_LAST) begin
          ack_err_nx = 1'b1;
          state_nx   = IDLE;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div_cnt    <= 8'd0;
      bit_cnt    <= 7'd0;
      cnt        <= 16'd0;
      sr         <= '0;
      sck        <= 1'b0;
      load       <= 1'b0;
      busy       <= 1'b0;
      pkt_valid  <= 1'b0;
      hdr_err    <= 1'b0;
      ack_err    <= 1'b0;
      quat_w     <= 16'sd0;
      quat_x     <= 16'sd0;
      quat_y     <= 16'sd0;
      quat_z     <= 16'sd0;
      gyro_x     <= 16'sd0;
      gyro_y     <= 16'sd0;
      gyro_z     <= 16'sd0;
      quat_valid <= 1'b0;
      gyro_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      div_cnt   <= div_cnt_nx;
      bit_cnt   <= bit_cnt_nx;
      cnt       <= cnt_nx;
      sr        <= sr_nx;
      sck       <= sck_nx;
      load      <= load_nx;
      busy      <= (state_nx != IDLE);
      pkt_valid <= pkt_valid_nx;
      hdr_err   <= hdr_err_nx;
      ack_err   <= ack_err_nx;
      if (pkt_valid_nx) begin
        quat_w     <= sr[119:104];
        quat_x     <= sr[103:88];
        quat_y     <= sr[87:72];
        quat_z     <= sr[71:56];
        gyro_x     <= sr[55:40];
        gyro_y     <= sr[39:24];
        gyro_z     <= sr[23:8];
        gyro_valid <= sr[1];
        quat_valid <= sr[0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sensor_pkt_spi_master.sv
`default_nettype none
// tb_sensor_pkt_spi_master : randomized packets from a slave model, checked
// every cycle against a packet-level reference model plus literal pins.
module tb_sensor_pkt_spi_master;
  localparam int CLK_DIV     = 2;
  localparam int LOAD_CYCLES = 8;
  localparam int ACK_TIMEOUT = 40;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, done = 1'b0;
  logic sdi, sck, sdo, load, busy, quat_valid, gyro_valid, pkt_valid, hdr_err, ack_err;
  logic signed [15:0] quat_w, quat_x, quat_y, quat_z, gyro_x, gyro_y, gyro_z;

  int total = 0;
  int passed = 0;

  // slave model: shifts the armed packet out MSB-first, advancing on sck falls
  int          sfalls = 0;
  int          sbase = 0;
  int          soff;
  logic [6:0]  sidx;
  logic [127:0] cur_pkt = '0;
  logic [7:0]  p_hdr = 8'h00;
  logic [15:0] p_q [4];
  logic [15:0] p_g [3];
  logic [1:0]  p_fl = 2'b00;

  assign soff = sfalls - sbase;
  assign sidx = 7'(127 - soff);
  assign sdi  = (soff >= 0 && soff < 128) ? cur_pkt[sidx] : 1'b0;

  sensor_pkt_spi_master #(
    .CLK_DIV(CLK_DIV), .LOAD_CYCLES(LOAD_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sck(sck), .sdo(sdo), .sdi(sdi),
    .done(done), .load(load), .busy(busy),
    .quat_w(quat_w), .quat_x(quat_x), .quat_y(quat_y), .quat_z(quat_z),
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
    .quat_valid(quat_valid), .gyro_valid(gyro_valid),
    .pkt_valid(pkt_valid), .hdr_err(hdr_err), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge sck);
    sfalls++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- per-cycle compare process -----------------
  int m_cyc = 0, m_rises = 0, m_falls = 0, m_run = 0;
  int m_res = -100000, m_ack = -100000;
  logic m_prev_sck = 1'b0, m_held = 1'b0, m_acc = 1'b0;
  logic [113:0] m_exp = '0;

  initial forever begin
    @(negedge clk);
    m_cyc++;
    if (!rst_n) begin
      m_rises = 0; m_falls = 0; m_run = 0;
      m_res = -100000; m_ack = -100000;
      m_prev_sck = 1'b0; m_exp = '0;
    end else begin
      check("sdo", sdo, 1'b0);
      if (!busy) check("idle_sck_load", {sck, load}, 2'b00);
      if (busy) begin
        if (sck !== m_prev_sck) begin
          if (sck) begin
            m_rises++;
            check("low_phase_len", m_run, CLK_DIV);
          end else begin
            m_falls++;
            check("high_phase_len", m_run, CLK_DIV);
            if (m_falls == 128) m_res = m_cyc + 1;
          end
          m_run = 1;
        end else begin
          m_run++;
        end
      end else begin
        m_rises = 0; m_falls = 0; m_run = 0;
      end
      m_prev_sck = sck;

      if (m_cyc == m_res) begin
        check("rise_count", m_rises, 128);
`ifdef PKT_HDR_CHECK_EN
        m_acc = (p_hdr == 8'hAA);
        check("hdr_err", hdr_err, !m_acc);
`else
        m_acc = 1'b1;
        check("hdr_err", hdr_err, 1'b0);
`endif
        if (m_acc) m_exp = {p_q[0], p_q[1], p_q[2], p_q[3], p_g[0], p_g[1], p_g[2], p_fl[0], p_fl[1]};
        check("pkt_valid", pkt_valid, m_acc);
        m_ack  = m_res + LOAD_CYCLES + ACK_TIMEOUT;
        m_held = 1'b1;
      end else begin
        check("pulse_quiet", {pkt_valid, hdr_err}, 2'b00);
      end
      check("load", load, (m_cyc >= m_res && m_cyc < m_res + LOAD_CYCLES));
      if (m_cyc <= m_ack - 2) m_held = m_held & done;
      check("ack_err", ack_err, (m_cyc == m_ack) && m_held);
      check("data", {quat_w, quat_x, quat_y, quat_z, gyro_x, gyro_y, gyro_z, quat_valid, gyro_valid}, m_exp);
    end
  end

  // ---------------- stimulus helpers -----------------
  task automatic arm(input logic [7:0] hdr, input logic [15:0] q0, q1, q2, q3, g0, g1, g2,
                     input logic [1:0] fl);
    p_hdr = hdr; p_q[0] = q0; p_q[1] = q1; p_q[2] = q2; p_q[3] = q3;
    p_g[0] = g0; p_g[1] = g1; p_g[2] = g2; p_fl = fl;
    cur_pkt = {hdr, q0, q1, q2, q3, g0, g1, g2, 6'b0, fl};
    sbase = sfalls;
  endtask

  task automatic wait_busy(input logic lvl, input int bound, input string name);
    int n = 0;
    while (busy !== lvl && n < bound) begin @(posedge clk); #1; n++; end
    if (busy !== lvl) check({name, "_timeout"}, busy, lvl);
  endtask

  task automatic wait_falls(input int nf);
    int n = 0;
    while ((sfalls - sbase) < nf && n < 3000) begin @(posedge clk); #1; n++; end
    if ((sfalls - sbase) < nf) check("falls_timeout", sfalls - sbase, nf);
  endtask

  task automatic wait_load();
    int n = 0;
    while (load !== 1'b1 && n < 3000) begin @(posedge clk); #1; n++; end
    if (load !== 1'b1) check("load_timeout", load, 1'b1);
  endtask

  task automatic send(input logic [7:0] hdr, input logic [15:0] q0, q1, q2, q3, g0, g1, g2,
                      input logic [1:0] fl, input int drop_fall, input int drop_delay);
    arm(hdr, q0, q1, q2, q3, g0, g1, g2, fl);
    @(posedge clk); #1 done = 1'b1;
    if (drop_fall >= 0) begin
      wait_falls(drop_fall);
      done = 1'b0;
    end
    wait_load();
    repeat (drop_delay) @(posedge clk);
    #1 done = 1'b0;
    wait_busy(1'b0, 200, "xfer_end");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence -----------------
  initial begin
    int n, lc, sc;
    logic [7:0] hdr;
    int dfall;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", {sck, sdo, load, busy, pkt_valid, hdr_err, ack_err}, 7'b0);
    check("rst_data", {quat_w, quat_y, gyro_x, gyro_z, quat_valid, gyro_valid}, 66'b0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // reference packet: latency, load width and decoded fields
    en = 1'b1;
    arm(8'hAA, 16'h4000, 16'hFFFF, 16'h0001, 16'h8000, 16'h0123, 16'hFEDC, 16'h7FFF, 2'b11);
    @(posedge clk); #1 done = 1'b1;
    n = 0;
    while (sck !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    check("first_rise_latency", n, 5);
    lc = 0; n = 0;
    while (n < 2000) begin
      @(posedge clk); #1; n++;
      if (load) lc++;
      if (lc == 3) done = 1'b0;
      if (!busy) break;
    end
    check("load_width", lc, 8);
    check("t1_quat_w", {quat_w}, 16'h4000);
    check("t1_quat_z", {quat_z}, 16'h8000);
    check("t1_quat_z_signed", (quat_z == -32768), 1'b1);
    check("t1_gyro_y", {gyro_y}, 16'hFEDC);
    check("t1_valids", {quat_valid, gyro_valid}, 2'b11);

    // bad header
    send(8'h55, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 2'b01, -1, 2);
`ifdef PKT_HDR_CHECK_EN
    check("bad_hdr_hold_w", {quat_w}, 16'h4000);
    check("bad_hdr_hold_gv", gyro_valid, 1'b1);
`else
    check("nohdr_update_w", {quat_w}, 16'h1111);
    check("nohdr_update_gv", gyro_valid, 1'b0);
`endif

    // en low holds off the transfer; en dropping mid-transfer does not abort
    en = 1'b0;
    arm(8'hAA, 16'h0BAD, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 2'b10);
    @(posedge clk); #1 done = 1'b1;
    sc = 0;
    repeat (40) begin @(posedge clk); #1; if (busy || sck) sc++; end
    check("en0_no_activity", sc, 0);
    en = 1'b1;
    wait_falls(10);
    en = 1'b0;
    wait_load();
    repeat (3) @(posedge clk);
    #1 done = 1'b0;
    wait_busy(1'b0, 200, "en_drop_end");
    check("en_drop_quat_w", {quat_w}, 16'h0BAD);

    // acknowledge timeout, then restart only once en returns
    en = 1'b1;
    arm(8'hAA, 16'h7777, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 2'b01);
    @(posedge clk); #1 done = 1'b1;
    wait_falls(5);
    en = 1'b0;
    wait_load();
    wait_busy(1'b0, 200, "timeout_end");
    check("ack_err_seen", ack_err, 1'b1);
    sc = 0;
    repeat (20) begin @(posedge clk); #1; if (busy || sck) sc++; end
    check("timeout_idle", sc, 0);
    sbase = sfalls;
    en = 1'b1;
    wait_busy(1'b1, 20, "restart");
    wait_load();
    repeat (2) @(posedge clk);
    #1 done = 1'b0;
    wait_busy(1'b0, 200, "restart_end");

    // reset mid-transfer, then a clean packet
    arm(8'hAA, 16'h1357, 16'h2468, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 2'b11);
    @(posedge clk); #1 done = 1'b1;
    wait_falls(60);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {sck, load, busy}, 3'b000);
    check("rst_mid_data", {quat_w, gyro_z, quat_valid, gyro_valid}, 34'b0);
    done = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    send(8'hAA, 16'h4000, 16'hFFFF, 16'h0001, 16'h8000, 16'h0123, 16'hFEDC, 16'h7FFF, 2'b11, -1, 3);
    check("post_rst_quat_x", {quat_x}, 16'hFFFF);
    check("post_rst_gyro_z", {gyro_z}, 16'h7FFF);

    // randomized packets, some with bad headers or done dropped mid-shift
    for (int i = 0; i < 8; i++) begin
      hdr   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hAA;
      dfall = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 120)) : -1;
      send(hdr, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom),
           dfall, int'($urandom_range(0, 6)));
      repeat (int'($urandom_range(1, 5))) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
